// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the
// valid/ready channel towards the decoder. master = fetch unit side.
interface busca_instrucao_if #(
  parameter int ADDR_BITS = 32
);
  logic                 mem_req;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_ack;
  logic [31:0]          mem_rdata;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [31:0]          instrucao;
  logic [ADDR_BITS-1:0] pc_instr;

  modport master (
    output mem_req, mem_addr, instr_valid, instrucao, pc_instr,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instrucao, pc_instr,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: PC, single-outstanding memory reads, fetch FIFO, redirect.
// Optional stall-cycle counter output ciclos_espera enabled by BUSCA_CONTADORES_EN.
module busca_instrucao #(
  parameter int                   ADDR_BITS  = 32,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 desvio_en,
  input  logic [ADDR_BITS-1:0] desvio_pc,
  busca_instrucao_if.master    bus
`ifdef BUSCA_CONTADORES_EN
  , output logic [15:0]        ciclos_espera
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {OCIOSO, BUSCA, ESPERA, DESCARTE} estado_t;

  estado_t              estado_q, estado_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_BITS-1:0] alvo_q, alvo_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_BITS-1:0] fifo_pc_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] fifo_pc_d [FIFO_DEPTH];
  logic [31:0]          fifo_word_q [FIFO_DEPTH];
  logic [31:0]          fifo_word_d [FIFO_DEPTH];

  logic                 ack, pop, push;
  logic [ADDR_BITS-1:0] alvo_novo;

`ifdef BUSCA_CONTADORES_EN
  logic [15:0] espera_q, espera_d;
`endif

  always_comb begin
    estado_d    = estado_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    alvo_d      = alvo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_word_d = fifo_word_q;

    ack       = mem_req_q && bus.mem_ack;
    pop       = (count_q != '0) && bus.instr_ready;
    push      = ack && (estado_q == BUSCA);
    alvo_novo = desvio_pc & ~ADDR_BITS'(3);

    if (desvio_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // An unanswered request must still be drained; its data is dropped later.
      if ((estado_q == BUSCA || estado_q == DESCARTE) && !ack) begin
        estado_d = DESCARTE;
        alvo_d   = alvo_novo;
      end else begin
        estado_d   = BUSCA;
        mem_req_d  = 1'b1;
        mem_addr_d = alvo_novo;
      end
    end else begin
      if (push) begin
        fifo_pc_d[tail_q]   = mem_addr_q;
        fifo_word_d[tail_q] = bus.mem_rdata;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (estado_q)
        OCIOSO: begin
          estado_d  = BUSCA;
          mem_req_d = 1'b1;
        end
        BUSCA: begin
          if (ack) begin
            mem_addr_d = mem_addr_q + ADDR_BITS'(4);
            if (count_d == CNT_W'(FIFO_DEPTH)) begin
              estado_d  = ESPERA;
              mem_req_d = 1'b0;
            end
          end
        end
        ESPERA: begin
          if (pop) begin
            estado_d  = BUSCA;
            mem_req_d = 1'b1;
          end
        end
        DESCARTE: begin
          if (ack) begin
            estado_d   = BUSCA;
            mem_req_d  = 1'b1;
            mem_addr_d = alvo_q;
          end
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

`ifdef BUSCA_CONTADORES_EN
  always_comb begin
    espera_d = espera_q;
    if (mem_req_q && !bus.mem_ack && espera_q != 16'hFFFF) begin
      espera_d = espera_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      alvo_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_word_q[i] <= '0;
      end
`ifdef BUSCA_CONTADORES_EN
      espera_q   <= '0;
`endif
    end else begin
      estado_q    <= estado_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      alvo_q      <= alvo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_word_q <= fifo_word_d;
`ifdef BUSCA_CONTADORES_EN
      espera_q    <= espera_d;
`endif
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instrucao   = fifo_word_q[head_q];
  assign bus.pc_instr    = fifo_pc_q[head_q];

`ifdef BUSCA_CONTADORES_EN
  assign ciclos_espera = espera_q;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: queue-based fetch model plus directed scenarios.
// Memory returns word == address; a second instance checks PC wrap from 0xFFFFFFF8.
module tb_busca_instrucao;

  localparam int AB    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        desvio_en = 1'b0;
  logic [31:0] desvio_pc = '0;
  logic        ready = 1'b0;
  logic        manual_mode = 1'b0;
  logic        manual_ack = 1'b0;
  logic        auto_ack = 1'b0;
  int          lat = 0;
  int          wcnt = 0;
  logic        desvio_off = 1'b0;
  logic [31:0] desvio_pc_off = '0;

  busca_instrucao_if #(.ADDR_BITS(AB)) bus ();
  busca_instrucao_if #(.ADDR_BITS(AB)) bus2 ();

  assign bus.mem_ack      = manual_mode ? manual_ack : auto_ack;
  assign bus.mem_rdata    = bus.mem_addr;
  assign bus.instr_ready  = ready;
  assign bus2.mem_ack     = bus2.mem_req;
  assign bus2.mem_rdata   = bus2.mem_addr;
  assign bus2.instr_ready = 1'b1;

`ifdef BUSCA_CONTADORES_EN
  logic [15:0] ciclos, ciclos2;
`endif

  busca_instrucao #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .desvio_en(desvio_en), .desvio_pc(desvio_pc), .bus(bus)
`ifdef BUSCA_CONTADORES_EN
    , .ciclos_espera(ciclos)
`endif
  );

  busca_instrucao #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .desvio_en(desvio_off), .desvio_pc(desvio_pc_off), .bus(bus2)
`ifdef BUSCA_CONTADORES_EN
    , .ciclos_espera(ciclos2)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: fetch buffer as a queue, next expected address, discard flag.
  typedef struct packed {logic [31:0] pc; logic [31:0] word;} entry_t;
  entry_t      mq[$];
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] pend = 32'h0;
  logic        discard = 1'b0;
  logic        started = 1'b0;
  logic [15:0] exp_ciclos = 16'h0;
  logic        m_acked;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_addr   = 32'h0;
        pend       = 32'h0;
        discard    = 1'b0;
        started    = 1'b0;
        exp_ciclos = 16'h0;
      end else begin
        m_acked = bus.mem_req && bus.mem_ack;
        if (bus.mem_req && !bus.mem_ack && exp_ciclos != 16'hFFFF) exp_ciclos = exp_ciclos + 16'd1;
        if (!started) begin
          started = 1'b1;
        end else if (desvio_en) begin
          mq.delete();
          if (bus.mem_req && !bus.mem_ack) begin
            discard = 1'b1;
            pend    = desvio_pc & ~32'h3;
          end else begin
            discard  = 1'b0;
            exp_addr = desvio_pc & ~32'h3;
          end
        end else begin
          if (mq.size() != 0 && ready) void'(mq.pop_front());
          if (m_acked) begin
            if (discard) begin
              discard  = 1'b0;
              exp_addr = pend;
            end else begin
              mq.push_back({exp_addr, exp_addr});
              exp_addr = exp_addr + 32'd4;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("instr_valid", {31'b0, bus.instr_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        checkOutput("instrucao", bus.instrucao, mq[0].word);
        checkOutput("pc_instr", bus.pc_instr, mq[0].pc);
      end
      checkOutput("mem_req", {31'b0, bus.mem_req},
                  {31'b0, started && (discard || mq.size() < DEPTH)});
      if (bus.mem_req) checkOutput("mem_addr", bus.mem_addr, exp_addr);
`ifdef BUSCA_CONTADORES_EN
      checkOutput("ciclos_espera", {16'b0, ciclos}, {16'b0, exp_ciclos});
`endif
    end
  end

  // Automatic memory: acks after lat waiting cycles, 0 means same-cycle ack.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        auto_ack = (wcnt == lat);
        wcnt     = auto_ack ? 0 : wcnt + 1;
      end else begin
        auto_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  task automatic applyStimulus(input logic rdy, input logic den, input logic [31:0] dpc,
                               input logic mman, input logic mack);
    ready       = rdy;
    desvio_en   = den;
    desvio_pc   = dpc;
    manual_mode = mman;
    manual_ack  = mack;
  endtask

  task automatic doReset(input int l, input logic rdy, input logic mman, input logic mack);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    lat = l;
    applyStimulus(rdy, 1'b0, 32'h0, mman, mack);
    checkOutput("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [31:0] wrap_exp [3];

  initial begin
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    // Zero-wait memory, decoder always ready; second instance shows PC wrap.
    doReset(0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_instrucao", bus.instrucao, 32'h0);
    checkOutput("rst_pc_instr", bus.pc_instr, 32'h0);
    checkOutput("rst_addr2", bus2.mem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("s1_addr", bus.mem_addr, 32'(4 * i));
      checkOutput("s1_req", {31'b0, bus.mem_req}, 32'h1);
      checkOutput("s1_valid", {31'b0, bus.instr_valid}, (i == 0) ? 32'h0 : 32'h1);
      if (i >= 1) begin
        checkOutput("s1_pc", bus.pc_instr, 32'(4 * (i - 1)));
        checkOutput("s1_word", bus.instrucao, 32'(4 * (i - 1)));
      end
      if (i < 3) checkOutput("wrap_addr", bus2.mem_addr, wrap_exp[i]);
      if (i == 2) checkOutput("wrap_pc", bus2.pc_instr, 32'hFFFF_FFFC);
    end

    // Decoder stalled, 2-cycle memory: buffer fills, request drops, one pop resumes.
    doReset(2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
    end
    checkOutput("s2_full_req", {31'b0, bus.mem_req}, 32'h0);
    checkOutput("s2_full_pc", bus.pc_instr, 32'h0);
    checkOutput("s2_full_n", 32'(mq.size()), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("s2_stray_req", {31'b0, bus.mem_req}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("s2_resume_req", {31'b0, bus.mem_req}, 32'h1);
    checkOutput("s2_resume_addr", bus.mem_addr, 32'h10);
    checkOutput("s2_resume_pc", bus.pc_instr, 32'h4);
    repeat (6) @(negedge clk);
    checkOutput("s2_refull_req", {31'b0, bus.mem_req}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

    // Redirect to 0x103 while 0x8 outstanding; ack arrives three cycles later.
    doReset(0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("s3_addr8", bus.mem_addr, 32'h8);
    applyStimulus(1'b1, 1'b1, 32'h103, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, k == 2);
      checkOutput("s3_hold_addr", bus.mem_addr, 32'h8);
      checkOutput("s3_hold_valid", {31'b0, bus.instr_valid}, 32'h0);
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("s3_new_addr", bus.mem_addr, 32'h100);
    checkOutput("s3_new_valid", {31'b0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("s3_wait_valid", {31'b0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    checkOutput("s3_first_pc", bus.pc_instr, 32'h100);
    checkOutput("s3_first_word", bus.instrucao, 32'h100);

    // Redirect and ack in the same cycle: acked word dropped.
    doReset(0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("s4_pre_pc", bus.pc_instr, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("s4_flush_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("s4_new_addr", bus.mem_addr, 32'h40);
    @(negedge clk);
    checkOutput("s4_first_pc", bus.pc_instr, 32'h40);
    checkOutput("s4_next_addr", bus.mem_addr, 32'h44);

    // Asynchronous reset with three entries held and a request pending.
    doReset(2, 1'b0, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    checkOutput("s6_pre_n", 32'(mq.size()), 32'd3);
    checkOutput("s6_pre_addr", bus.mem_addr, 32'hC);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_req", {31'b0, bus.mem_req}, 32'h0);
    checkOutput("s6_addr", bus.mem_addr, 32'h0);
    checkOutput("s6_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("s6_instrucao", bus.instrucao, 32'h0);
    checkOutput("s6_pc_instr", bus.pc_instr, 32'h0);
`ifdef BUSCA_CONTADORES_EN
    checkOutput("s6_ciclos", {16'b0, ciclos}, 32'h0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s6_restart_req", {31'b0, bus.mem_req}, 32'h1);
    checkOutput("s6_restart_addr", bus.mem_addr, 32'h0);
    repeat (10) @(negedge clk);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage directly upstream of the control decoder.
- Keeps the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over valid/ready.
- Handles branch redirects by flushing the buffer and discarding any in-flight response.

## Interface
- ADDR_BITS, 32, width of PC and memory address
- FIFO_DEPTH, 4, fetch buffer entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_req  out  1  read request to instruction memory
- mem_addr  out  ADDR_BITS  word-aligned read address
- mem_ack  in  1  memory completes current request; mem_rdata valid this cycle
- mem_rdata  in  32  instruction word
- desvio_en  in  1  redirect pulse from branch/jump resolution
- desvio_pc  in  ADDR_BITS  redirect target
- instr_valid  out  1  instrucao/pc_instr hold a valid entry
- instr_ready  in  1  decode accepts current entry
- instrucao  out  32  instruction word to decoder
- pc_instr  out  ADDR_BITS  PC of instrucao

## Operation
- FSM states:
  - OCIOSO: reset state only.
  - BUSCA: mem_req=1, waiting for ack.
  - ESPERA: FIFO full, mem_req=0.
  - DESCARTE: redirected while a request was outstanding; wait for ack and drop its data.
- Transitions:
  - OCIOSO→BUSCA: first edge after reset release.
  - BUSCA, ack, count after push/pop < FIFO_DEPTH → BUSCA at pc+4.
  - BUSCA, ack, buffer becomes full → ESPERA.
  - ESPERA→BUSCA: any pop.
  - DESCARTE, ack → BUSCA at the redirect PC.
- At most one request outstanding. mem_req is issued only when count < FIFO_DEPTH, so space is guaranteed when the ack arrives.
- While mem_req=1, mem_addr stays stable until the ack.
- Push on ack in BUSCA: {pc, mem_rdata} to tail. pc advances by 4, modulo 2^ADDR_BITS, so 0xFFFFFFFC wraps to 0.
- Pop when instr_valid && instr_ready. Outputs show head; instr_valid = (count≠0).
- Push and pop in the same cycle: count unchanged. Head/tail pointers wrap modulo FIFO_DEPTH.
- Redirect (desvio_en=1) has highest priority:
  - FIFO flushed (count=0); pop and push in that cycle are ignored.
  - pc ← desvio_pc with bits [1:0] forced to 0.
  - Request outstanding without ack this cycle → DESCARTE, mem_req held high at the old address until ack.
  - Ack in the same cycle, or state ESPERA → BUSCA at the new PC.
  - Redirect while in DESCARTE: target updated, state unchanged.
- Reset mid-operation: all state cleared immediately. A pending memory response is not tracked; memory is reset by the same rst_n.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instrucao=0, pc_instr=0.
  - FIFO count 0, state OCIOSO.
- mem_req and mem_addr are registered.
- mem_ack sampled at the edge while mem_req=1. An ack while mem_req=0 is ignored.
- Latency: ack in cycle N → instr_valid=1 with that word in cycle N+1.
- Zero-wait memory (ack in the same cycle as req): one fetch per cycle sustained, mem_req stays high, addresses step by 4.
- Redirect in cycle N: instr_valid=0 in N+1. The first new request is visible in N+1, or in the cycle after the discarded ack.
- instrucao and pc_instr stable while instr_valid=1 and instr_ready=0.

## Configuration
- BUSCA_CONTADORES_EN defined:
  - Adds output ciclos_espera, 16 bits: counts cycles with mem_req=1 and mem_ack=0.
  - Saturates at 0xFFFF; reset to 0; not cleared by redirect.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, zero-wait memory returning word=addr, instr_ready=1:
  - mem_addr 0,4,8,… on consecutive cycles.
  - instrucao/pc_instr 0,4,8,… one cycle behind.
- instr_ready=0, 2-cycle memory latency:
  - Exactly 4 words buffered, mem_req drops, state ESPERA.
  - One pop → request for 0x10 issued next cycle.
- Redirect to 0x103 while request at 0x8 outstanding, ack 3 cycles later:
  - mem_addr held at 0x8 until ack; that word never appears.
  - Next request at 0x100; instr_valid=0 until it returns.
- Redirect and ack in the same cycle:
  - Acked word dropped, FIFO empty next cycle, next request at the target.
- PC wrap: RESET_PC=0xFFFFFFF8 → fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- rst_n asserted with FIFO holding 3 entries and request pending:
  - All outputs return to reset values immediately.
  - Fetch restarts at RESET_PC. With BUSCA_CONTADORES_EN, ciclos_espera = 0.
